// File: rtl/tile_painter.sv
// Tile painter: latches a tile position/colour and rasters every pixel of it
// to the VGA adapter, then pulses done for one cycle.
module tile_painter #(
    parameter int         TILE_W       = 40,
    parameter int         TILE_H       = 40,
    parameter int         X_ORG        = 40,
    parameter int         Y_ORG        = 20,
    parameter logic [2:0] FLASH_COLOUR = 3'b111
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ld_tile,
    input  logic       ld_flash,
    input  logic [2:0] tile_num,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    // state | meaning
    // IDLE  | accept loads, wait for start
    // PAINT | one pixel per cycle, row-major
    // DONE  | single-cycle done pulse
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PAINT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] X_ORG_C = 8'(X_ORG);
    localparam logic [7:0] W_C     = 8'(TILE_W);
    localparam logic [6:0] Y_ORG_C = 7'(Y_ORG);
    localparam logic [6:0] H_C     = 7'(TILE_H);
    localparam logic [5:0] LAST_X  = 6'(TILE_W - 1);
    localparam logic [5:0] LAST_Y  = 6'(TILE_H - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_x0;
    logic [6:0] r_y0;
    logic [2:0] r_col;
    logic [5:0] r_cnt_x;
    logic [5:0] r_cnt_y;

    logic       w_last_x;
    logic       w_last_y;
    logic [7:0] w_ld_x0;
    logic [6:0] w_ld_y0;
    logic [2:0] w_base_col;

    assign w_last_x = (r_cnt_x == LAST_X);
    assign w_last_y = (r_cnt_y == LAST_Y);
    assign w_ld_x0  = X_ORG_C + (tile_num[0] ? W_C : 8'd0);
    assign w_ld_y0  = Y_ORG_C + (tile_num[1] ? H_C : 7'd0);

    always_comb begin
        w_base_col = 3'b000;
        if (!tile_num[2]) begin
            case (tile_num[1:0])
                2'd0:    w_base_col = 3'b100;
                2'd1:    w_base_col = 3'b010;
                2'd2:    w_base_col = 3'b001;
                default: w_base_col = 3'b110;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_PAINT;
            S_PAINT: if (w_last_x && w_last_y) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Loads are only honoured in IDLE; flash overrides the base colour when both arrive together.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_x0    <= X_ORG_C;
            r_y0    <= Y_ORG_C;
            r_col   <= 3'b000;
            r_cnt_x <= 6'd0;
            r_cnt_y <= 6'd0;
        end else if (r_state == S_IDLE) begin
            if (ld_tile) begin
                r_x0  <= w_ld_x0;
                r_y0  <= w_ld_y0;
                r_col <= w_base_col;
            end
            if (ld_flash) r_col <= FLASH_COLOUR;
            if (start) begin
                r_cnt_x <= 6'd0;
                r_cnt_y <= 6'd0;
            end
        end else if (r_state == S_PAINT) begin
            if (w_last_x) begin
                r_cnt_x <= 6'd0;
                r_cnt_y <= r_cnt_y + 6'd1;
            end else begin
                r_cnt_x <= r_cnt_x + 6'd1;
            end
        end
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        plot   = 1'b0;
        x      = 8'd0;
        y      = 7'd0;
        colour = 3'b000;
        case (r_state)
            S_PAINT: begin
                busy   = 1'b1;
                plot   = 1'b1;
                x      = r_x0 + {2'b00, r_cnt_x};
                y      = r_y0 + {1'b0, r_cnt_y};
                colour = r_col;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tile_painter.sv
// Self-checking bench for tile_painter: directed scenarios plus random loads,
// each paint compared pixel by pixel against a raster model.
module tb_tile_painter;

    localparam int         TILE_W = 40;
    localparam int         TILE_H = 40;
    localparam int         X_ORG  = 40;
    localparam int         Y_ORG  = 20;
    localparam int         NPIX   = TILE_W * TILE_H;
    localparam logic [2:0] FLASH  = 3'b111;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       ld_tile = 1'b0;
    logic       ld_flash = 1'b0;
    logic [2:0] tile_num = 3'd0;
    logic       start = 1'b0;
    logic       busy, done, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    int n_tests = 0;
    int n_fail  = 0;

    int         m_x0;
    int         m_y0;
    logic [2:0] m_col;
    logic [2:0] base_col [4];

    tile_painter #(
        .TILE_W(TILE_W), .TILE_H(TILE_H), .X_ORG(X_ORG), .Y_ORG(Y_ORG), .FLASH_COLOUR(FLASH)
    ) dut (
        .clock(clock), .resetn(resetn), .ld_tile(ld_tile), .ld_flash(ld_flash),
        .tile_num(tile_num), .start(start), .busy(busy), .done(done),
        .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #5 clock = ~clock;

    function automatic void model_reset();
        m_x0  = X_ORG;
        m_y0  = Y_ORG;
        m_col = 3'b000;
    endfunction

    function automatic void model_load(input bit lt, input bit lf, input logic [2:0] tn);
        if (lt) begin
            m_x0  = X_ORG + (tn[0] ? TILE_W : 0);
            m_y0  = Y_ORG + (tn[1] ? TILE_H : 0);
            m_col = tn[2] ? 3'b000 : base_col[tn[1:0]];
        end
        if (lf) m_col = FLASH;
    endfunction

    // Called just after a falling edge; the load is sampled at the next rising edge.
    task automatic do_load(input bit lt, input bit lf, input logic [2:0] tn);
        ld_tile  = lt;
        ld_flash = lf;
        tile_num = tn;
        model_load(lt, lf, tn);
        @(negedge clock);
        ld_tile  = 1'b0;
        ld_flash = 1'b0;
    endtask

    task automatic do_start(input bit lt, input bit lf, input logic [2:0] tn);
        ld_tile  = lt;
        ld_flash = lf;
        tile_num = tn;
        start    = 1'b1;
        model_load(lt, lf, tn);
        @(posedge clock);
        #1;
        ld_tile  = 1'b0;
        ld_flash = 1'b0;
        start    = 1'b0;
    endtask

    // Checks every pixel cycle, the done cycle and the return to idle. At pixel
    // index inject_at, drives start plus conflicting loads that must be ignored.
    task automatic paint_check(input string name, input int inject_at);
        int ex, ey;
        for (int i = 0; i < NPIX; i++) begin
            @(negedge clock);
            start = 1'b0; ld_tile = 1'b0; ld_flash = 1'b0;
            ex = m_x0 + (i % TILE_W);
            ey = m_y0 + (i / TILE_W);
            n_tests++;
            if (plot !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
                x !== 8'(ex) || y !== 7'(ey) || colour !== m_col) begin
                n_fail++;
                $display("FAIL %s pixel %0d: got plot=%b busy=%b done=%b x=%0d y=%0d colour=%b, expected plot=1 busy=1 done=0 x=%0d y=%0d colour=%b",
                         name, i, plot, busy, done, x, y, colour, ex, ey, m_col);
            end
            if (i == inject_at) begin
                start = 1'b1; ld_tile = 1'b1; ld_flash = 1'b1; tile_num = 3'd2;
            end
        end
        @(negedge clock);
        start = 1'b0; ld_tile = 1'b0; ld_flash = 1'b0;
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b1 || plot !== 1'b0 || x !== 8'd0 || y !== 7'd0 || colour !== 3'b000) begin
            n_fail++;
            $display("FAIL %s done_cycle: got done=%b busy=%b plot=%b x=%0d y=%0d colour=%b, expected done=1 busy=1 plot=0 x=0 y=0 colour=000",
                     name, done, busy, plot, x, y, colour);
        end
        start = 1'b1;  // must be ignored while in the done cycle
        @(negedge clock);
        start = 1'b0;
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || plot !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: got done=%b busy=%b plot=%b, expected 0 0 0", name, done, busy, plot);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #23;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy=%b done=%b plot=%b, expected 0 0 0", busy, done, plot);
        end
        n_tests++;
        if (x !== 8'd0 || y !== 7'd0 || colour !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pix: got x=%0d y=%0d colour=%b, expected 0 0 000", x, y, colour);
        end
        @(negedge clock);
        resetn = 1'b1;
        model_reset();
        @(negedge clock);
    endtask

    task automatic test_default_paint();
        do_start(1'b0, 1'b0, 3'd0);
        paint_check("default", -1);
    endtask

    task automatic test_tile0();
        do_load(1'b1, 1'b0, 3'd0);
        do_start(1'b0, 1'b0, 3'd0);
        paint_check("tile0", -1);
    endtask

    task automatic test_flash();
        do_load(1'b1, 1'b0, 3'd3);
        do_load(1'b0, 1'b1, 3'd3);
        do_start(1'b0, 1'b0, 3'd3);
        paint_check("flash3", -1);
    endtask

    task automatic test_clear();
        do_load(1'b1, 1'b0, 3'd6);
        do_start(1'b0, 1'b0, 3'd6);
        paint_check("clear6", -1);
    endtask

    task automatic test_ignore_midpaint();
        do_load(1'b1, 1'b0, 3'd1);
        do_start(1'b0, 1'b0, 3'd1);
        paint_check("ignore_mid", 700);
    endtask

    task automatic test_load_with_start();
        do_load(1'b1, 1'b0, 3'd0);
        do_start(1'b1, 1'b0, 3'd1);
        paint_check("load_with_start", -1);
    endtask

    task automatic test_reset_midpaint();
        int bad = 0;
        do_load(1'b1, 1'b0, 3'd0);
        do_start(1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 500; i++) @(negedge clock);
        n_tests++;
        if (plot !== 1'b1 || x !== 8'(X_ORG + 499 % TILE_W) || y !== 7'(Y_ORG + 499 / TILE_W)) begin
            n_fail++;
            $display("FAIL reset_mid_pixel500: got plot=%b x=%0d y=%0d, expected plot=1 x=%0d y=%0d",
                     plot, x, y, X_ORG + 499 % TILE_W, Y_ORG + 499 / TILE_W);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got plot=%b busy=%b, expected 0 0", plot, busy);
        end
        @(negedge clock);
        resetn = 1'b1;
        model_reset();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (done !== 1'b0 || plot !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got %0d cycles with done/plot high, expected 0", bad);
        end
        do_start(1'b0, 1'b0, 3'd0);
        paint_check("after_reset", -1);
    endtask

    task automatic test_random();
        bit         lt, lf, same;
        logic [2:0] tn;
        for (int k = 0; k < 4; k++) begin
            tn   = 3'($urandom_range(0, 7));
            lt   = 1'($urandom_range(0, 1));
            lf   = 1'($urandom_range(0, 1));
            same = 1'($urandom_range(0, 1));
            if (same) begin
                do_start(lt, lf, tn);
            end else begin
                do_load(lt, lf, tn);
                do_start(1'b0, 1'b0, tn);
            end
            paint_check($sformatf("random%0d_tn%0d_lt%0d_lf%0d", k, tn, lt, lf), -1);
        end
    endtask

    initial begin
        base_col[0] = 3'b100;
        base_col[1] = 3'b010;
        base_col[2] = 3'b001;
        base_col[3] = 3'b110;
        model_reset();
        test_reset();
        test_default_paint();
        test_tile0();
        test_flash();
        test_clear();
        test_ignore_midpaint();
        test_load_with_start();
        test_reset_midpaint();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_painter.md
Name: tile_painter

Overview:
- Pixel-drawing datapath directly downstream of the memory-game graphics controller.
- Latches a tile selection and colour from the controller's load strobes. On a one-cycle start strobe, it walks every pixel of that tile and emits x/y/colour/plot to the 160x120, 3-bit-colour VGA adapter.
- Pulses done when the tile is finished so the controller can sequence the next draw.

Parameters:
- TILE_W, 40, tile width in pixels (1..63)
- TILE_H, 40, tile height in pixels (1..63)
- X_ORG, 40, x of the top-left tile's left edge; X_ORG+2*TILE_W <= 160
- Y_ORG, 20, y of the top-left tile's top edge; Y_ORG+2*TILE_H <= 120
- FLASH_COLOUR, 3'b111, colour used when ld_flash is applied

Ports:
- clock, input, 1, sole clock, rising edge
- resetn, input, 1, asynchronous active-low reset
- ld_tile, input, 1, latch position and base colour from tile_num
- ld_flash, input, 1, override latched colour with FLASH_COLOUR
- tile_num, input, 3, [1:0] tile index; [2]=1 selects clear (black)
- start, input, 1, one-cycle strobe to begin painting the latched tile
- busy, output, 1, high while painting
- done, output, 1, one-cycle pulse after the last pixel
- x, output, 8, pixel x to VGA adapter
- y, output, 7, pixel y to VGA adapter
- colour, output, 3, pixel colour to VGA adapter
- plot, output, 1, VGA write enable

Behaviour:
- Tile geometry:
  - tile_num[0]=1 adds TILE_W to x origin; tile_num[1]=1 adds TILE_H to y origin.
  - Tile 0 is top-left, 1 top-right, 2 bottom-left, 3 bottom-right.
- Base colours: 0 red 3'b100, 1 green 3'b010, 2 blue 3'b001, 3 yellow 3'b110. If tile_num[2]=1, colour is 3'b000.
- Registers: x0[7:0], y0[6:0], col[2:0], cnt_x[5:0], cnt_y[5:0], 2-bit state.
- Reset (async, any state):
  - state=IDLE, x0=X_ORG, y0=Y_ORG, col=000, counters=0.
  - Outputs: busy=0, done=0, plot=0, x=0, y=0, colour=0.
- Loads (IDLE only; ignored in PAINT and DONE):
  - ld_tile: x0/y0/col from tile_num.
  - ld_flash: col=FLASH_COLOUR; position unchanged.
  - Both in the same cycle: position from tile_num, col=FLASH_COLOUR.
- State machine (Moore; all outputs decode registered state only):
  - IDLE:
    - start=1 -> PAINT, cnt_x=cnt_y=0.
    - A load in the same cycle as start is applied first; painting uses the new values.
  - PAINT:
    - Each cycle: plot=1, busy=1, x=x0+cnt_x, y=y0+cnt_y, colour=col.
    - cnt_x increments. At cnt_x=TILE_W-1 it wraps to 0 and cnt_y increments.
    - At cnt_x=TILE_W-1 and cnt_y=TILE_H-1 -> DONE.
    - start is ignored.
  - DONE: plot=0, busy=1, done=1 for exactly one cycle -> IDLE; start ignored.
  - IDLE outputs: plot=0, busy=0, done=0, x/y/colour=0.
- Timing:
  - start sampled at edge 0; first pixel is visible in cycle 1; last pixel in cycle TILE_W*TILE_H.
  - done is high in cycle TILE_W*TILE_H+1.
  - Earliest next start: the cycle after done.
- Arithmetic: x and y sums are zero-extended; no overflow is possible under the parameter constraints.
- Raster order: row-major, left to right, top to bottom. No pixel is repeated or skipped.
- Reset mid-PAINT: plot drops immediately (asynchronously). No done pulse follows. Latched tile is lost.

Test Plan:
- Reset -> busy=0, done=0, plot=0, x=0, y=0, colour=0. With no load, start paints tile at (40,20) in colour 000.
- ld_tile with tile_num=0, then start:
  - 1600 plot cycles, colour 100.
  - First pixel (40,20), pixel 41 at (40,21), last (79,59).
  - done is a single pulse at cycle 1601; busy drops the following cycle.
- ld_tile with tile_num=3, then ld_flash, then start -> colour 111 throughout, first (80,60), last (119,99).
- ld_tile with tile_num=6 -> colour 000 over (40,60)..(79,99).
- Mid-paint of tile 1: pulse start, and ld_tile with tile_num=2 -> ignored. Paint stays green at x 80..119, y 20..59, exactly 1600 plots.
- ld_tile (tile_num=1) and start in the same cycle -> first pixel (80,20), colour 010.
- Reset at pixel 500 -> plot=0 immediately; done stays 0 for 2000 following cycles.
